// File: rtl/pipe_pkg.sv
// Shared types for the decode stage: target-select encoding and the ID/EX payload layout.
package pipe_pkg;

  // Build widths of the default 32-bit, 32-register configuration.
  localparam int unsigned PipeXlen = 32;
  localparam int unsigned PipeAw   = 5;

  typedef enum logic [1:0] {
    TGT_BR   = 2'b00,
    TGT_JAL  = 2'b01,
    TGT_JALR = 2'b10
  } tgt_sel_e;

  // Payload carried from ID to EX.
  typedef struct packed {
    logic [PipeXlen-1:0] rs1_data;
    logic [PipeXlen-1:0] rs2_data;
    logic [PipeXlen-1:0] pc;
    logic [PipeXlen-1:0] tgt;
    logic [PipeAw-1:0]   rd;
    logic                is_load;
  } id_ex_t;

endpackage

// File: rtl/regfile_bypass.sv
// Register file with async clear, two combinational read ports and write-first bypass.
module regfile_bypass #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned NREG = 32,
  parameter int unsigned AW   = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wb_load,
  input  logic [AW-1:0]   wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data
);

  logic [XLEN-1:0] mem_q [NREG];
  logic [XLEN-1:0] mem_d [NREG];
  logic            wr_en;

  assign wr_en = wb_load && (wb_rd != '0);

  // Next-state of the array: one entry updated on writeback, register 0 never written.
  always_comb begin
    mem_d = mem_q;
    if (wr_en) begin
      mem_d[wb_rd] = wb_data;
    end
  end

  // Array storage, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NREG); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  // Reads: register 0 is hard zero; an in-flight writeback to the same index wins.
  always_comb begin
    rs1_data = mem_q[rs1];
    rs2_data = mem_q[rs2];
    if (wr_en && (wb_rd == rs1)) rs1_data = wb_data;
    if (wr_en && (wb_rd == rs2)) rs2_data = wb_data;
    if (rs1 == '0) rs1_data = '0;
    if (rs2 == '0) rs2_data = '0;
  end

endmodule

// File: rtl/id_stage_pipe.sv
// Decode stage: operand read with bypass, target adder, load-use hazard and ID/EX register.
module id_stage_pipe
  import pipe_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned NREG = 32,
  parameter int unsigned AW   = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  output logic            id_ready,
  input  logic [AW-1:0]   id_rs1,
  input  logic [AW-1:0]   id_rs2,
  input  logic [AW-1:0]   id_rd,
  input  logic [XLEN-1:0] id_pc,
  input  logic [XLEN-1:0] id_b_imm,
  input  logic [XLEN-1:0] id_j_imm,
  input  logic [XLEN-1:0] id_i_imm,
  input  logic [1:0]      id_tgt_sel,
  input  logic            id_is_load,
  input  logic            wb_load,
  input  logic [AW-1:0]   wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            flush,
  input  logic            ex_ready,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_rs1_data,
  output logic [XLEN-1:0] ex_rs2_data,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_tgt,
  output logic [AW-1:0]   ex_rd,
  output logic            ex_is_load
);

  logic [XLEN-1:0] rs1_data, rs2_data;
  logic [XLEN-1:0] jalr_sum, tgt;
  logic            advance, hazard;

  logic            ex_valid_q, ex_valid_d;
  logic [XLEN-1:0] ex_rs1_data_q, ex_rs1_data_d;
  logic [XLEN-1:0] ex_rs2_data_q, ex_rs2_data_d;
  logic [XLEN-1:0] ex_pc_q, ex_pc_d;
  logic [XLEN-1:0] ex_tgt_q, ex_tgt_d;
  logic [AW-1:0]   ex_rd_q, ex_rd_d;
  logic            ex_is_load_q, ex_is_load_d;

  regfile_bypass #(
    .XLEN(XLEN),
    .NREG(NREG),
    .AW  (AW)
  ) u_regfile (
    .clk     (clk),
    .rst     (rst),
    .wb_load (wb_load),
    .wb_rd   (wb_rd),
    .wb_data (wb_data),
    .rs1     (id_rs1),
    .rs2     (id_rs2),
    .rs1_data(rs1_data),
    .rs2_data(rs2_data)
  );

  // Control-flow target; the unused select code falls back to the branch target.
  always_comb begin
    jalr_sum = rs1_data + id_i_imm;
    tgt      = id_pc + id_b_imm;
    case (id_tgt_sel)
      TGT_JAL:  tgt = id_pc + id_j_imm;
      TGT_JALR: tgt = jalr_sum & {{(XLEN-1){1'b1}}, 1'b0};
      default:  ;
    endcase
  end

  // Handshake: EX slot free or draining; stall while a load in EX feeds either source.
  always_comb begin
    advance  = ~ex_valid_q | ex_ready;
    hazard   = ex_valid_q & ex_is_load_q & (ex_rd_q != '0) &
               ((ex_rd_q == id_rs1) | (ex_rd_q == id_rs2));
    id_ready = flush | (advance & ~hazard);
  end

  // ID/EX next state: flush, then bubble on hazard, then capture; payload holds otherwise.
  always_comb begin
    ex_valid_d    = ex_valid_q;
    ex_rs1_data_d = ex_rs1_data_q;
    ex_rs2_data_d = ex_rs2_data_q;
    ex_pc_d       = ex_pc_q;
    ex_tgt_d      = ex_tgt_q;
    ex_rd_d       = ex_rd_q;
    ex_is_load_d  = ex_is_load_q;
    if (flush) begin
      ex_valid_d = 1'b0;
    end else if (advance) begin
      if (hazard || !id_valid) begin
        ex_valid_d = 1'b0;
      end else begin
        ex_valid_d    = 1'b1;
        ex_rs1_data_d = rs1_data;
        ex_rs2_data_d = rs2_data;
        ex_pc_d       = id_pc;
        ex_tgt_d      = tgt;
        ex_rd_d       = id_rd;
        ex_is_load_d  = id_is_load;
      end
    end
  end

  // ID/EX pipeline register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid_q    <= 1'b0;
      ex_rs1_data_q <= '0;
      ex_rs2_data_q <= '0;
      ex_pc_q       <= '0;
      ex_tgt_q      <= '0;
      ex_rd_q       <= '0;
      ex_is_load_q  <= 1'b0;
    end else begin
      ex_valid_q    <= ex_valid_d;
      ex_rs1_data_q <= ex_rs1_data_d;
      ex_rs2_data_q <= ex_rs2_data_d;
      ex_pc_q       <= ex_pc_d;
      ex_tgt_q      <= ex_tgt_d;
      ex_rd_q       <= ex_rd_d;
      ex_is_load_q  <= ex_is_load_d;
    end
  end

  assign ex_valid    = ex_valid_q;
  assign ex_rs1_data = ex_rs1_data_q;
  assign ex_rs2_data = ex_rs2_data_q;
  assign ex_pc       = ex_pc_q;
  assign ex_tgt      = ex_tgt_q;
  assign ex_rd       = ex_rd_q;
  assign ex_is_load  = ex_is_load_q;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Bench for id_stage_pipe: directed scenarios plus random traffic against a transaction model.
module tb_id_stage_pipe;
  import pipe_pkg::*;

  localparam int unsigned XLEN = 32;
  localparam int unsigned NREG = 32;
  localparam int unsigned AW   = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic            id_valid, id_ready;
  logic [AW-1:0]   id_rs1, id_rs2, id_rd;
  logic [XLEN-1:0] id_pc, id_b_imm, id_j_imm, id_i_imm;
  logic [1:0]      id_tgt_sel;
  logic            id_is_load;
  logic            wb_load;
  logic [AW-1:0]   wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            flush, ex_ready, ex_valid;
  logic [XLEN-1:0] ex_rs1_data, ex_rs2_data, ex_pc, ex_tgt;
  logic [AW-1:0]   ex_rd;
  logic            ex_is_load;

  always #5 clk = ~clk;

  id_stage_pipe #(.XLEN(XLEN), .NREG(NREG)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_ready(id_ready),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_pc(id_pc),
    .id_b_imm(id_b_imm), .id_j_imm(id_j_imm), .id_i_imm(id_i_imm),
    .id_tgt_sel(id_tgt_sel), .id_is_load(id_is_load), .wb_load(wb_load),
    .wb_rd(wb_rd), .wb_data(wb_data), .flush(flush), .ex_ready(ex_ready),
    .ex_valid(ex_valid), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
    .ex_pc(ex_pc), .ex_tgt(ex_tgt), .ex_rd(ex_rd), .ex_is_load(ex_is_load)
  );

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  // Reference model: architectural registers plus the one instruction sitting in EX.
  logic [XLEN-1:0] m_regs [NREG];
  logic            m_valid;
  id_ex_t          m_ex;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [31:0] m_read(input logic [4:0] rs);
    if (rs == 5'd0) return 32'd0;
    if (wb_load && wb_rd == rs) return wb_data;
    return m_regs[rs];
  endfunction

  function automatic logic m_stall();
    return m_valid && !ex_ready;
  endfunction

  function automatic logic m_load_use();
    return m_valid && m_ex.is_load && m_ex.rd != 5'd0 && (m_ex.rd == id_rs1 || m_ex.rd == id_rs2);
  endfunction

  function automatic logic m_ready();
    return flush || (!m_stall() && !m_load_use());
  endfunction

  function automatic logic [31:0] m_target();
    case (id_tgt_sel)
      2'b01:   return id_pc + id_j_imm;
      2'b10:   return (m_read(id_rs1) + id_i_imm) & 32'hFFFF_FFFE;
      default: return id_pc + id_b_imm;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < int'(NREG); i++) m_regs[i] = '0;
    m_valid = 1'b0;
    m_ex    = '0;
  endtask

  // Advance the model across one clock edge using the inputs currently applied.
  task automatic model_step();
    logic lu, st;
    lu = m_load_use();
    st = m_stall();
    if (flush) begin
      m_valid = 1'b0;
    end else if (!st) begin
      if (lu || !id_valid) begin
        m_valid = 1'b0;
      end else begin
        m_ex.rs1_data = m_read(id_rs1);
        m_ex.rs2_data = m_read(id_rs2);
        m_ex.pc       = id_pc;
        m_ex.tgt      = m_target();
        m_ex.rd       = id_rd;
        m_ex.is_load  = id_is_load;
        m_valid       = 1'b1;
      end
    end
    if (wb_load && wb_rd != 5'd0) m_regs[wb_rd] = wb_data;
  endtask

  task automatic compare_ex();
    check_eq("ex_valid", 32'(ex_valid), 32'(m_valid));
    check_eq("ex_rs1_data", ex_rs1_data, m_ex.rs1_data);
    check_eq("ex_rs2_data", ex_rs2_data, m_ex.rs2_data);
    check_eq("ex_pc", ex_pc, m_ex.pc);
    check_eq("ex_tgt", ex_tgt, m_ex.tgt);
    check_eq("ex_rd", 32'(ex_rd), 32'(m_ex.rd));
    check_eq("ex_is_load", 32'(ex_is_load), 32'(m_ex.is_load));
  endtask

  // Inputs are applied just after a rising edge; this checks id_ready, then steps one edge.
  task automatic cycle();
    #1;
    check_eq("id_ready", 32'(id_ready), 32'(m_ready()));
    model_step();
    @(posedge clk);
    #1;
    compare_ex();
  endtask

  task automatic idle_inputs();
    id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0; id_pc = 0;
    id_b_imm = 0; id_j_imm = 0; id_i_imm = 0; id_tgt_sel = 2'b00; id_is_load = 0;
    wb_load = 0; wb_rd = 0; wb_data = 0; flush = 0; ex_ready = 1;
  endtask

  task automatic instr(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic ld);
    id_valid = 1; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd; id_is_load = ld;
    id_pc = $urandom; id_b_imm = $urandom; id_j_imm = $urandom; id_i_imm = $urandom;
    id_tgt_sel = 2'($urandom_range(0, 3));
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic async_reset();
    rst = 1'b1;
    #1;
    check_eq("rst_ex_valid", 32'(ex_valid), 32'd0);
    check_eq("rst_ex_rs1", ex_rs1_data, 32'd0);
    check_eq("rst_ex_rs2", ex_rs2_data, 32'd0);
    check_eq("rst_ex_pc", ex_pc, 32'd0);
    check_eq("rst_ex_tgt", ex_tgt, 32'd0);
    check_eq("rst_ex_rd", 32'(ex_rd), 32'd0);
    check_eq("rst_ex_is_load", 32'(ex_is_load), 32'd0);
    model_reset();
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_ex();
    rst = 1'b0;
    #1;
    check_eq("reset_id_ready", 32'(id_ready), 32'd1);

    // Same-cycle writeback bypass into the operand read.
    instr(5'd5, 5'd0, 5'd1, 1'b0);
    wb_load = 1; wb_rd = 5'd5; wb_data = 32'hDEAD_BEEF;
    cycle();
    check_eq("bypass_rs1", ex_rs1_data, 32'hDEAD_BEEF);
    wb_load = 0;
    cycle();
    check_eq("stored_rs1", ex_rs1_data, 32'hDEAD_BEEF);

    // Branch target with a negative offset, then jalr with bit 0 cleared.
    instr(5'd0, 5'd0, 5'd2, 1'b0);
    id_pc = 32'h100; id_b_imm = 32'hFFFF_FFF8; id_tgt_sel = 2'b00;
    cycle();
    check_eq("br_target", ex_tgt, 32'h0000_00F8);
    id_valid = 0; wb_load = 1; wb_rd = 5'd3; wb_data = 32'h203;
    cycle();
    instr(5'd3, 5'd0, 5'd4, 1'b0);
    wb_load = 0; id_i_imm = 32'd4; id_tgt_sel = 2'b10;
    cycle();
    check_eq("jalr_target", ex_tgt, 32'h0000_0206);

    // Load-use: one stall cycle producing a bubble, then capture.
    instr(5'd0, 5'd0, 5'd7, 1'b1);
    cycle();
    instr(5'd1, 5'd7, 5'd9, 1'b0);
    #1;
    check_eq("lu_stall", 32'(id_ready), 32'd0);
    cycle();
    check_eq("lu_bubble", 32'(ex_valid), 32'd0);
    check_eq("lu_ready_after", 32'(id_ready), 32'd1);
    cycle();
    check_eq("lu_capture_valid", 32'(ex_valid), 32'd1);
    check_eq("lu_capture_rd", 32'(ex_rd), 32'd9);

    // Backpressure for three cycles: EX contents hold, ID stalls; then the next one lands.
    instr(5'd0, 5'd0, 5'd10, 1'b0);
    cycle();
    instr(5'd2, 5'd3, 5'd11, 1'b0);
    ex_ready = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_eq("bp_id_ready", 32'(id_ready), 32'd0);
      cycle();
      check_eq("bp_hold_rd", 32'(ex_rd), 32'd10);
    end
    ex_ready = 1;
    cycle();
    check_eq("bp_land_rd", 32'(ex_rd), 32'd11);

    // Flush together with a hazard and backpressure; a write to register 0 is dropped.
    instr(5'd0, 5'd0, 5'd7, 1'b1);
    cycle();
    instr(5'd7, 5'd0, 5'd12, 1'b0);
    ex_ready = 0; flush = 1;
    wb_load = 1; wb_rd = 5'd0; wb_data = 32'h0000_FFFF;
    #1;
    check_eq("flush_id_ready", 32'(id_ready), 32'd1);
    cycle();
    check_eq("flush_ex_valid", 32'(ex_valid), 32'd0);
    flush = 0; wb_load = 0; ex_ready = 1;
    instr(5'd0, 5'd0, 5'd13, 1'b0);
    id_tgt_sel = 2'b10; id_i_imm = 32'h0;
    cycle();
    check_eq("r0_reads_zero", ex_rs1_data, 32'd0);

    // Random traffic; small index range keeps hazards and bypasses frequent.
    for (int n = 0; n < 500; n++) begin
      instr(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            1'($urandom_range(0, 2) == 0));
      id_valid = 1'($urandom_range(0, 4) != 0);
      wb_load  = 1'($urandom_range(0, 1));
      wb_rd    = 5'($urandom_range(0, 7));
      wb_data  = $urandom;
      flush    = 1'($urandom_range(0, 9) == 0);
      ex_ready = 1'($urandom_range(0, 9) < 7);
      if (n == 250) begin
        // Reset in the middle of a stall.
        ex_ready = 0; flush = 0;
        #2;
        async_reset();
        idle_inputs();
        for (int r = 1; r < int'(NREG); r++) begin
          instr(5'(r), 5'(NREG - r), 5'd1, 1'b0);
          cycle();
          check_eq("post_rst_rf1", ex_rs1_data, 32'd0);
          check_eq("post_rst_rf2", ex_rs2_data, 32'd0);
        end
      end else begin
        cycle();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
